// File: rtl/delay_load_pkg.sv
// Shared constants and state type for the software delay-load controller.
// Used by delay_load_ctrl and reg_word_settle.
package delay_load_pkg;

    localparam int REQ_BIT           = 31;
    localparam int IMM_BIT           = 30;
    localparam int DEFAULT_DELAY_W   = 12;
    localparam int DEFAULT_MAX_DELAY = 4095;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_e;

endpackage

// File: rtl/reg_word_settle.sv
// Two-stage settle pipeline for a software register word, with rising-edge
// request detection on one selectable bit, evaluated only on stable cycles.
module reg_word_settle
    import delay_load_pkg::*;
#(
    parameter int W        = 32,
    parameter int EDGE_BIT = REQ_BIT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] word_in,
    output logic [W-1:0] word,
    output logic         req
);

    logic [W-1:0] d1_q, d1_d;
    logic [W-1:0] d2_q, d2_d;
    logic [1:0]   fill_q, fill_d;
    logic         primed_q, primed_d;
    logic         last_q, last_d;
    logic         stable_s;

    // fill_q keeps the reset-cleared history from counting as a stable word,
    // so a request bit already high at reset release only primes the detector.
    assign stable_s = fill_q[1] & (d1_q == d2_q);
    assign req      = primed_q & stable_s & d1_q[EDGE_BIT] & ~last_q;
    assign word     = d1_q;

    // Next-state for the settle pipeline and edge-detect history.
    always_comb begin
        d1_d     = word_in;
        d2_d     = d1_q;
        fill_d   = {fill_q[0], 1'b1};
        primed_d = primed_q;
        last_d   = last_q;
        if (stable_s) begin
            primed_d = 1'b1;
            last_d   = d1_q[EDGE_BIT];
        end else begin
            primed_d = primed_q;
            last_d   = last_q;
        end
    end

    // Settle pipeline and edge-detect state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1_q     <= '0;
            d2_q     <= '0;
            fill_q   <= 2'b00;
            primed_q <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            d1_q     <= d1_d;
            d2_q     <= d2_d;
            fill_q   <= fill_d;
            primed_q <= primed_d;
            last_q   <= last_d;
        end
    end

endmodule

// File: rtl/delay_load_ctrl.sv
// Applies a clamped coarse delay from a software word, immediately or on the
// next F-engine sync. Define DELAY_LOAD_CNT_EN to add the load_count port.
module delay_load_ctrl
    import delay_load_pkg::*;
#(
    parameter int DELAY_W   = DEFAULT_DELAY_W,
    parameter int MAX_DELAY = DEFAULT_MAX_DELAY,
    parameter int CNT_W     = 16
) (
    input  logic               user_clk,
    input  logic               user_rst_n,
    input  logic [31:0]        user_data_in,
    input  logic               sync_in,
    output logic [DELAY_W-1:0] delay_out,
    output logic               delay_load,
    output logic               armed,
    output logic               clamped
`ifdef DELAY_LOAD_CNT_EN
    ,
    output logic [CNT_W-1:0]   load_count
`endif
);

    localparam logic [31:0]        MAX_W = 32'(MAX_DELAY);
    localparam logic [DELAY_W-1:0] MAX_V = DELAY_W'(MAX_DELAY);

    logic [31:0]        word_s;
    logic               req_s;
    logic               imm_s;
    logic [DELAY_W-1:0] new_raw_s;
    logic [DELAY_W-1:0] new_val_s;
    logic               new_clamp_s;
    logic               unused_word_s;

    state_e             state_q, state_d;
    logic [DELAY_W-1:0] pend_val_q, pend_val_d;
    logic               pend_clamp_q, pend_clamp_d;
    logic [DELAY_W-1:0] delay_out_q, delay_out_d;
    logic               delay_load_q, delay_load_d;
    logic               armed_q, armed_d;
    logic               clamped_q, clamped_d;

    reg_word_settle #(
        .W        (32),
        .EDGE_BIT (REQ_BIT)
    ) u_settle (
        .clk     (user_clk),
        .rst_n   (user_rst_n),
        .word_in (user_data_in),
        .word    (word_s),
        .req     (req_s)
    );

    assign imm_s         = word_s[IMM_BIT];
    assign new_raw_s     = word_s[DELAY_W-1:0];
    assign new_clamp_s   = (32'(new_raw_s) > MAX_W);
    assign new_val_s     = new_clamp_s ? MAX_V : new_raw_s;
    assign unused_word_s = ^{word_s[REQ_BIT], word_s[IMM_BIT-1:DELAY_W]};

    // Load FSM: capture on request, apply now or on the next sync. A new
    // request in ARMED is evaluated after the sync so it re-arms or overrides.
    always_comb begin
        state_d      = state_q;
        pend_val_d   = pend_val_q;
        pend_clamp_d = pend_clamp_q;
        delay_out_d  = delay_out_q;
        clamped_d    = clamped_q;
        delay_load_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_s) begin
                    pend_val_d   = new_val_s;
                    pend_clamp_d = new_clamp_s;
                    if (imm_s) begin
                        delay_out_d  = new_val_s;
                        clamped_d    = new_clamp_s;
                        delay_load_d = 1'b1;
                    end else begin
                        state_d = ARMED;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ARMED: begin
                if (sync_in) begin
                    delay_out_d  = pend_val_q;
                    clamped_d    = pend_clamp_q;
                    delay_load_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    state_d = ARMED;
                end
                if (req_s) begin
                    pend_val_d   = new_val_s;
                    pend_clamp_d = new_clamp_s;
                    if (imm_s) begin
                        delay_out_d  = new_val_s;
                        clamped_d    = new_clamp_s;
                        delay_load_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        state_d = ARMED;
                    end
                end else begin
                    pend_val_d = pend_val_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        armed_d = (state_d == ARMED);
    end

    // Control state and registered outputs.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state_q      <= IDLE;
            pend_val_q   <= '0;
            pend_clamp_q <= 1'b0;
            delay_out_q  <= '0;
            delay_load_q <= 1'b0;
            armed_q      <= 1'b0;
            clamped_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_val_q   <= pend_val_d;
            pend_clamp_q <= pend_clamp_d;
            delay_out_q  <= delay_out_d;
            delay_load_q <= delay_load_d;
            armed_q      <= armed_d;
            clamped_q    <= clamped_d;
        end
    end

    assign delay_out  = delay_out_q;
    assign delay_load = delay_load_q;
    assign armed      = armed_q;
    assign clamped    = clamped_q;

`ifdef DELAY_LOAD_CNT_EN
    logic [CNT_W-1:0] load_count_q, load_count_d;

    // Counts applied loads, wrapping naturally at the counter width.
    always_comb begin
        if (delay_load_d) begin
            load_count_d = load_count_q + CNT_W'(1);
        end else begin
            load_count_d = load_count_q;
        end
    end

    // Load counter register.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            load_count_q <= '0;
        end else begin
            load_count_q <= load_count_d;
        end
    end

    assign load_count = load_count_q;
`else
    logic [CNT_W-1:0] unused_cnt_s;
    assign unused_cnt_s = '0;
`endif

endmodule

// File: tb/tb_delay_load_ctrl.sv
// Randomized self-checking bench for delay_load_ctrl with a queue-based
// reference model and directed literal checkpoints.
module tb_delay_load_ctrl;

    localparam int DW   = 13;
    localparam int MAXD = 4095;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [31:0]   data = 32'h0;
    logic          sync = 1'b0;
    logic [DW-1:0] delay_out;
    logic          delay_load;
    logic          armed;
    logic          clamped;
`ifdef DELAY_LOAD_CNT_EN
    logic [15:0]   load_count;
`endif

    delay_load_ctrl #(.DELAY_W(DW), .MAX_DELAY(MAXD), .CNT_W(16)) dut (
        .user_clk     (clk),
        .user_rst_n   (rst_n),
        .user_data_in (data),
        .sync_in      (sync),
        .delay_out    (delay_out),
        .delay_load   (delay_load),
        .armed        (armed),
        .clamped      (clamped)
`ifdef DELAY_LOAD_CNT_EN
        ,
        .load_count   (load_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int seen_loads = 0;

    typedef struct {
        string name;
        int    sel;
        int    val;
    } lit_t;
    lit_t lit_q[$];

    // reference model state
    logic [31:0] hist[$];
    bit primed_m = 0, last_m = 0, armed_m = 0, pclamp_m = 0;
    int pend_m = 0;
    int exp_out = 0, exp_cnt = 0;
    bit exp_load = 0, exp_armed = 0, exp_clamp = 0;
    bit m_req, m_fire, m_imm, m_clp;
    int m_raw, m_val;
    logic [31:0] m_w;

    // Model: a word counts once the two most recent samples agree; a load
    // request is a rising request bit among counted words after the first.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist.delete();
            primed_m = 0; last_m = 0; armed_m = 0; pend_m = 0; pclamp_m = 0;
            exp_out = 0; exp_load = 0; exp_armed = 0; exp_clamp = 0; exp_cnt = 0;
        end else begin
            m_req = 0;
            m_fire = 0;
            m_imm = 0;
            if (hist.size() == 2 && hist[0] == hist[1]) begin
                m_w = hist[1];
                m_req = primed_m && m_w[31] && !last_m;
                primed_m = 1;
                last_m = m_w[31];
            end
            if (m_req) begin
                m_raw = int'(m_w[DW-1:0]);
                m_clp = (m_raw > MAXD);
                m_val = m_clp ? MAXD : m_raw;
                m_imm = m_w[30];
            end
            if (armed_m && sync) begin
                exp_out = pend_m; exp_clamp = pclamp_m; m_fire = 1; armed_m = 0;
            end
            if (m_req) begin
                if (m_imm) begin
                    exp_out = m_val; exp_clamp = m_clp; m_fire = 1; armed_m = 0;
                end else begin
                    pend_m = m_val; pclamp_m = m_clp; armed_m = 1;
                end
            end
            exp_load = m_fire;
            exp_armed = armed_m;
            if (m_fire) exp_cnt = (exp_cnt + 1) % 65536;
            hist.push_back(data);
            if (hist.size() > 2) void'(hist.pop_front());
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int field(input int sel);
        case (sel)
            0: return int'(delay_out);
            1: return int'(delay_load);
            2: return int'(armed);
            3: return int'(clamped);
            default: return seen_loads;
        endcase
    endfunction

    // Compare process: model on every cycle plus any queued literal checkpoints.
    always @(negedge clk) begin
        #1;
        if (delay_load) seen_loads++;
        chk("delay_out", int'(delay_out), exp_out);
        chk("delay_load", int'(delay_load), int'(exp_load));
        chk("armed", int'(armed), int'(exp_armed));
        chk("clamped", int'(clamped), int'(exp_clamp));
`ifdef DELAY_LOAD_CNT_EN
        chk("load_count", int'(load_count), exp_cnt);
`endif
        while (lit_q.size() > 0) begin
            lit_t l;
            l = lit_q.pop_front();
            chk(l.name, field(l.sel), l.val);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic lit(input string nm, input int sel, input int v);
        lit_t l;
        l.name = nm; l.sel = sel; l.val = v;
        lit_q.push_back(l);
    endtask

    logic [31:0] w;

    initial begin
        // reset with the request bit already high
        data = 32'h8000_0010;
        #1 rst_n = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(10);
        lit("rst_delay_out", 0, 0);
        lit("rst_armed", 2, 0);
        lit("rst_no_load", 4, 0);

        // immediate load
        data = 32'h0000_0064; cyc(5);
        data = 32'hC000_0064; cyc(2);
        lit("imm_not_early", 1, 0);
        cyc(1);
        lit("imm_load", 1, 1);
        lit("imm_out", 0, 100);
        lit("imm_clamped", 3, 0);
        lit("imm_armed", 2, 0);
        cyc(1);
        lit("imm_one_cycle", 1, 0);

        // load on sync
        data = 32'h0000_0200; cyc(5);
        data = 32'h8000_0200; cyc(3);
        lit("arm_set", 2, 1);
        cyc(20);
        lit("arm_hold", 2, 1);
        lit("arm_out_old", 0, 100);
        sync = 1'b1; cyc(1); sync = 1'b0;
        lit("sync_load", 1, 1);
        lit("sync_out", 0, 512);
        lit("sync_disarm", 2, 0);

        // clamp
        data = 32'h4000_1FFF; cyc(5);
        data = 32'hC000_1FFF; cyc(3);
        lit("clamp_out", 0, 4095);
        lit("clamp_flag", 3, 1);

        // request together with sync while armed
        data = 32'h0000_0005; cyc(5);
        data = 32'h8000_0005; cyc(4);
        lit("rearm_armed", 2, 1);
        data = 32'h0000_0007; cyc(5);
        data = 32'h8000_0007; cyc(2);
        sync = 1'b1; cyc(1); sync = 1'b0;
        lit("both_out_old", 0, 5);
        lit("both_load", 1, 1);
        lit("both_still_armed", 2, 1);
        lit("both_clamp_clr", 3, 0);
        cyc(5);
        sync = 1'b1; cyc(1); sync = 1'b0;
        lit("both_out_new", 0, 7);
        lit("both_disarm", 2, 0);

        // never-stable word
        for (int i = 0; i < 20; i++) begin
            data = (i % 2 == 0) ? 32'h8000_0033 : 32'h0000_0044;
            cyc(1);
        end
        data = 32'h0000_0044; cyc(4);
        lit("toggle_out", 0, 7);
        lit("toggle_armed", 2, 0);

        // reset while armed
        data = 32'h8000_0009; cyc(4);
        lit("pre_rst_armed", 2, 1);
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        lit("rst_armed_drop", 2, 0);
        lit("rst_out_clear", 0, 0);
        cyc(2); rst_n = 1'b1;
        cyc(5);
        sync = 1'b1; cyc(1); sync = 1'b0;
        lit("rst_no_strobe", 1, 0);
        cyc(3);
        lit("rst_out_after", 0, 0);

        // random traffic
        w = 32'h0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 0) w = w ^ 32'h8000_0000;
                else w = $urandom;
            end
            data = w;
            sync = ($urandom_range(0, 7) == 0);
            cyc(1);
        end
        sync = 1'b0;
        cyc(3);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
